// File: rtl/m_clint.sv
// -----------------------------------------------------------------------------
// m_clint - core-local interruptor for the RISC-V cluster.
//
// Owns the free-running 64-bit mtime counter (advanced by a TICK_DIV
// prescaler), one 64-bit mtimecmp and one msip bit per hart, and makes them
// visible through a single-cycle-request MMIO slave. Every request, whether
// mapped or not, is acknowledged exactly one cycle later with no stall.
//
// Register map (byte offsets within the 64 KiB window, h = hart index):
//   0x0000 + 4h   msip[h]          bit 0 only, upper bits read as zero
//   0x4000 + 8h   mtimecmp[h] lo
//   0x4004 + 8h   mtimecmp[h] hi
//   0xBFF8        mtime lo
//   0xBFFC        mtime hi
//   anything else (including h >= N_HARTS): writes dropped, reads return 0
//
// Parameters:
//   N_HARTS   number of harts, 1..16
//   TICK_DIV  CLK cycles per mtime increment, >= 1
//
// Ports:
//   CLK       sole clock, rising edge
//   RST       asynchronous active-high reset
//   w_req     request valid for one cycle
//   w_we      1 = write, 0 = read (qualified by w_req)
//   w_addr    byte offset, bits [1:0] ignored
//   w_wdata   write data
//   r_ack     response strobe, one cycle after the request
//   r_rdata   read data, valid with r_ack, holds otherwise
//   w_mtime   current mtime
//   w_mtip    timer interrupt pending, one bit per hart
//   w_msip    software interrupt pending, one bit per hart
// -----------------------------------------------------------------------------
module m_clint #(
    parameter int unsigned N_HARTS  = 1,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               w_req,
    input  logic               w_we,
    input  logic [15:0]        w_addr,
    input  logic [31:0]        w_wdata,
    output logic               r_ack,
    output logic [31:0]        r_rdata,
    output logic [63:0]        w_mtime,
    output logic [N_HARTS-1:0] w_mtip,
    output logic [N_HARTS-1:0] w_msip
);

    localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HART_W = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    // Word (address >> 2) indices of the register regions.
    localparam logic [13:0] CMP_BASE_W = 14'h1000;
    localparam logic [13:0] CMP_END_W  = CMP_BASE_W + 14'(2 * N_HARTS);
    localparam logic [13:0] MTIME_LO_W = 14'h2FFE;
    localparam logic [13:0] MTIME_HI_W = 14'h2FFF;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0]   div_q,      div_d;
    logic [63:0]        mtime_q,    mtime_d;
    logic [63:0]        mtimecmp_q [N_HARTS];
    logic [63:0]        mtimecmp_d [N_HARTS];
    logic [N_HARTS-1:0] msip_q,     msip_d;
    logic [N_HARTS-1:0] mtip_q,     mtip_d;
    logic               ack_q;
    logic [31:0]        rdata_q,    rdata_d;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [13:0]       word;
    logic [13:0]       cmp_off;
    logic              msip_hit;
    logic              cmp_hit;
    logic              cmp_hi;
    logic              mtime_lo_hit;
    logic              mtime_hi_hit;
    logic [HART_W-1:0] hart_idx;
    logic              unused_addr_lsbs;

    assign word             = w_addr[15:2];
    assign unused_addr_lsbs = ^w_addr[1:0];

    // NOTE: every signal assigned in an always_comb gets a default on the
    // first lines of the block, so no path leaves it unassigned and no latch
    // is inferred; the combinational blocks use blocking '=' throughout.
    always_comb begin
        msip_hit     = 1'b0;
        cmp_hit      = 1'b0;
        cmp_hi       = 1'b0;
        cmp_off      = word - CMP_BASE_W;
        hart_idx     = '0;
        mtime_lo_hit = (word == MTIME_LO_W);
        mtime_hi_hit = (word == MTIME_HI_W);

        if (word < 14'(N_HARTS)) begin
            msip_hit = 1'b1;
            hart_idx = HART_W'(word);
        end else if (word >= CMP_BASE_W && word < CMP_END_W) begin
            // Two words per hart: bit 0 picks the half, the rest the hart.
            cmp_hit  = 1'b1;
            cmp_hi   = cmp_off[0];
            hart_idx = HART_W'(cmp_off >> 1);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic tick;
    logic wr;
    logic rd;

    assign tick = (div_q == DIV_LAST);
    assign wr   = w_req & w_we;
    assign rd   = w_req & ~w_we;

    // Prescaler runs independently of mtime writes.
    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
    end

    // A half-write replaces that half and suppresses the increment for the
    // cycle, so the other half keeps its un-incremented value (no carry).
    always_comb begin
        mtime_d = mtime_q + 64'(tick);
        if (wr && mtime_lo_hit) begin
            mtime_d = {mtime_q[63:32], w_wdata};
        end else if (wr && mtime_hi_hit) begin
            mtime_d = {w_wdata, mtime_q[31:0]};
        end
    end

    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        if (wr && msip_hit) begin
            msip_d[hart_idx] = w_wdata[0];
        end
        if (wr && cmp_hit) begin
            if (cmp_hi) begin
                mtimecmp_d[hart_idx][63:32] = w_wdata;
            end else begin
                mtimecmp_d[hart_idx][31:0] = w_wdata;
            end
        end
    end

    // The pending bit compares the registered mtime/mtimecmp, so it trails
    // any tick or write by one further cycle: a write in cycle N moves w_mtip
    // in cycle N+2, and w_mtip rises the cycle after mtime reaches mtimecmp.
    always_comb begin
        mtip_d = '0;
        for (int h = 0; h < N_HARTS; h++) begin
            mtip_d[h] = (mtime_q >= mtimecmp_q[h]);
        end
    end

    // Reads see the register values standing in the request cycle.
    always_comb begin
        rdata_d = rdata_q;
        if (rd) begin
            rdata_d = '0;
            if (msip_hit) begin
                rdata_d = {31'b0, msip_q[hart_idx]};
            end else if (cmp_hit) begin
                rdata_d = cmp_hi ? mtimecmp_q[hart_idx][63:32]
                                 : mtimecmp_q[hart_idx][31:0];
            end else if (mtime_lo_hit) begin
                rdata_d = mtime_q[31:0];
            end else if (mtime_hi_hit) begin
                rdata_d = mtime_q[63:32];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: mtimecmp is a small register array, not a RAM; every entry must
    // reset to all-ones so no hart sees a spurious timer interrupt, hence the
    // reset loop over the array.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q   <= '0;
            mtime_q <= '0;
            msip_q  <= '0;
            mtip_q  <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            for (int h = 0; h < N_HARTS; h++) begin
                mtimecmp_q[h] <= '1;
            end
        end else begin
            div_q      <= div_d;
            mtime_q    <= mtime_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            ack_q      <= w_req;
            rdata_q    <= rdata_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    assign r_ack   = ack_q;
    assign r_rdata = rdata_q;
    assign w_mtime = mtime_q;
    assign w_mtip  = mtip_q;
    assign w_msip  = msip_q;

endmodule

// File: tb/tb_m_clint.sv
// -----------------------------------------------------------------------------
// tb_m_clint - self-checking bench for m_clint (N_HARTS=2, TICK_DIV=4).
//
// A behavioural model tracks mtime, mtimecmp, msip, the pending bits and the
// response path from the register-map rules; a compare process checks every
// DUT output against it on each falling edge outside reset. Directed
// sequences pin the model with literal expectations, then random MMIO
// traffic runs against the model.
// -----------------------------------------------------------------------------
module tb_m_clint;

    localparam int N_HARTS  = 2;
    localparam int TICK_DIV = 4;

    logic               CLK     = 1'b0;
    logic               RST     = 1'b0;
    logic               w_req   = 1'b0;
    logic               w_we    = 1'b0;
    logic [15:0]        w_addr  = '0;
    logic [31:0]        w_wdata = '0;
    logic               r_ack;
    logic [31:0]        r_rdata;
    logic [63:0]        w_mtime;
    logic [N_HARTS-1:0] w_mtip;
    logic [N_HARTS-1:0] w_msip;

    m_clint #(.N_HARTS(N_HARTS), .TICK_DIV(TICK_DIV)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .w_req   (w_req),
        .w_we    (w_we),
        .w_addr  (w_addr),
        .w_wdata (w_wdata),
        .r_ack   (r_ack),
        .r_rdata (r_rdata),
        .w_mtime (w_mtime),
        .w_mtip  (w_mtip),
        .w_msip  (w_msip)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    logic [63:0]        m_mtime;
    logic [63:0]        m_cmp [N_HARTS];
    logic [N_HARTS-1:0] m_msip;
    logic [N_HARTS-1:0] m_mtip;
    logic               m_ack;
    logic [31:0]        m_rdata;
    int unsigned        m_cyc;   // rising edges since reset release

    function automatic logic [31:0] model_read(input logic [15:0] a);
        int unsigned off = {a[15:2], 2'b00};
        if (off < 4 * N_HARTS) return {31'b0, m_msip[off / 4]};
        if (off >= 'h4000 && off < 'h4000 + 8 * N_HARTS)
            return (off % 8 == 4) ? m_cmp[(off - 'h4000) / 8][63:32]
                                  : m_cmp[(off - 'h4000) / 8][31:0];
        if (off == 'hBFF8) return m_mtime[31:0];
        if (off == 'hBFFC) return m_mtime[63:32];
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_mtime = '0;
        for (int h = 0; h < N_HARTS; h++) m_cmp[h] = '1;
        m_msip  = '0;
        m_mtip  = '0;
        m_ack   = 1'b0;
        m_rdata = '0;
        m_cyc   = 0;
    endtask

    task automatic model_step();
        logic [63:0] old;
        int unsigned off;
        for (int h = 0; h < N_HARTS; h++) m_mtip[h] = (m_mtime >= m_cmp[h]);
        m_ack = w_req;
        if (w_req && !w_we) m_rdata = model_read(w_addr);
        old = m_mtime;
        if (m_cyc % TICK_DIV == TICK_DIV - 1) m_mtime = old + 64'd1;
        m_cyc++;
        if (w_req && w_we) begin
            off = {w_addr[15:2], 2'b00};
            if (off < 4 * N_HARTS) m_msip[off / 4] = w_wdata[0];
            else if (off >= 'h4000 && off < 'h4000 + 8 * N_HARTS) begin
                if (off % 8 == 4) m_cmp[(off - 'h4000) / 8][63:32] = w_wdata;
                else              m_cmp[(off - 'h4000) / 8][31:0]  = w_wdata;
            end
            else if (off == 'hBFF8) m_mtime = {old[63:32], w_wdata};
            else if (off == 'hBFFC) m_mtime = {w_wdata, old[31:0]};
        end
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) model_reset();
        else     model_step();
    end

    // Compare process: every output, every falling edge outside reset.
    always @(negedge CLK) begin
        if (!RST) begin
            check("mtime", w_mtime, m_mtime);
            check("mtip",  w_mtip,  m_mtip);
            check("msip",  w_msip,  m_msip);
            check("ack",   r_ack,   m_ack);
            check("rdata", r_rdata, m_rdata);
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge, return at the next one,
    // which is the ack cycle of the request)
    // -------------------------------------------------------------------------
    task automatic req(input logic we, input logic [15:0] a, input logic [31:0] d);
        w_req   = 1'b1;
        w_we    = we;
        w_addr  = a;
        w_wdata = d;
        @(negedge CLK);
        w_req   = 1'b0;
    endtask

    logic [15:0] addr_pool [12] = '{16'h0000, 16'h0004, 16'h0008, 16'h4000,
                                    16'h4004, 16'h4008, 16'h400C, 16'h4010,
                                    16'hBFF8, 16'hBFFC, 16'hBFF4, 16'h1234};

    initial begin
        logic [63:0] last;
        int          prev_i;
        int          k;
        logic [31:0] exp_lo;
        logic [15:0] a;
        logic [31:0] d;

        // ---------------- reset state ----------------
        #1 RST = 1'b1;
        #1;
        check("rst_mtime", w_mtime, 64'h0);
        check("rst_mtip",  w_mtip,  2'b00);
        check("rst_msip",  w_msip,  2'b00);
        check("rst_ack",   r_ack,   1'b0);
        check("rst_rdata", r_rdata, 32'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // ---------------- tick spacing ----------------
        last   = '0;
        prev_i = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (w_mtime !== last) begin
                if (prev_i < 0) check("first_tick_cycle", i, 3);
                else            check("tick_gap", i - prev_i, TICK_DIV);
                prev_i = i;
                last   = w_mtime;
            end
        end
        check("mtime_after_40", w_mtime, 64'd10);

        // ---------------- mtimecmp reset readback ----------------
        req(1'b0, 16'h4000, '0); check("cmp0_lo_rst", r_rdata, 32'hFFFF_FFFF);
        req(1'b0, 16'h4004, '0); check("cmp0_hi_rst", r_rdata, 32'hFFFF_FFFF);
        req(1'b0, 16'h400C, '0); check("cmp1_hi_rst", r_rdata, 32'hFFFF_FFFF);

        // ---------------- timer interrupt ----------------
        req(1'b1, 16'h4008, 32'h20);
        req(1'b1, 16'h400C, 32'h0);
        for (k = 0; k < 200 && w_mtime !== 64'h20; k++) @(negedge CLK);
        check("reach_mtime_20", k < 200, 1'b1);
        check("mtip1_not_yet", w_mtip[1], 1'b0);
        @(negedge CLK);
        check("mtip1_rise", w_mtip[1], 1'b1);
        check("mtip0_quiet", w_mtip[0], 1'b0);
        req(1'b1, 16'h4008, 32'h1000);
        check("mtip1_n1_still_set", w_mtip[1], 1'b1);
        @(negedge CLK);
        check("mtip1_n2_clear", w_mtip[1], 1'b0);

        // ---------------- software interrupt ----------------
        req(1'b1, 16'h0004, 32'hFFFF_FFFF);
        check("msip_n1", w_msip, 2'b10);
        req(1'b0, 16'h0004, '0);
        check("msip1_read", r_rdata, 32'h1);

        // ---------------- wrap ----------------
        req(1'b1, 16'hBFFC, 32'hFFFF_FFFF);
        req(1'b1, 16'hBFF8, 32'hFFFF_FFFF);
        check("mtime_all_ones", w_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        for (k = 0; k < 2 * TICK_DIV && w_mtime === 64'hFFFF_FFFF_FFFF_FFFF; k++)
            @(negedge CLK);
        check("mtime_wrap", w_mtime, 64'h0);

        // ---------------- write/tick collision ----------------
        while (m_cyc % TICK_DIV != TICK_DIV - 1) @(negedge CLK);
        req(1'b1, 16'hBFF8, 32'h5);
        check("collide_lo", w_mtime[31:0], 32'h5);
        check("collide_hi", w_mtime[63:32], 32'h0);

        // ---------------- unmapped + back-to-back ----------------
        req(1'b0, 16'h0000, '0);
        req(1'b0, 16'h4004, '0);
        check("cmp0_hi_read", r_rdata, 32'hFFFF_FFFF);
        req(1'b0, 16'h0008, '0);
        check("unmapped_ack", r_ack, 1'b1);
        check("unmapped_data", r_rdata, 32'h0);
        exp_lo = m_mtime[31:0];
        req(1'b0, 16'hBFF8, '0);
        check("b2b_ack", r_ack, 1'b1);
        check("b2b_mtime_lo", r_rdata, exp_lo);
        @(negedge CLK);
        check("ack_one_cycle", r_ack, 1'b0);
        check("rdata_hold", r_rdata, exp_lo);

        // ---------------- random traffic ----------------
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(9) < 7) begin
                a = addr_pool[$urandom_range(11)] | 16'($urandom_range(3));
                case ($urandom_range(3))
                    0:       d = $urandom;
                    1:       d = 32'($urandom_range(1));
                    default: d = 32'($urandom_range(400));
                endcase
                req(1'($urandom_range(1)), a, d);
            end else begin
                @(negedge CLK);
            end
        end

        // ---------------- asynchronous reset mid-operation ----------------
        req(1'b1, 16'h0000, 32'h1);
        req(1'b0, 16'h0000, '0);
        #2 RST = 1'b1;
        #1;
        check("arst_mtime", w_mtime, 64'h0);
        check("arst_mtip",  w_mtip,  2'b00);
        check("arst_msip",  w_msip,  2'b00);
        check("arst_ack",   r_ack,   1'b0);
        check("arst_rdata", r_rdata, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        req(1'b0, 16'h4000, '0); check("arst_cmp0_lo", r_rdata, 32'hFFFF_FFFF);
        req(1'b0, 16'h4004, '0); check("arst_cmp0_hi", r_rdata, 32'hFFFF_FFFF);
        check("arst_mtip_after", w_mtip, 2'b00);
        repeat (3) @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
